// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with byte-lane writes and a self-clearing start-up phase.
// Optional bounds checking of byte addresses is enabled by defining DATA_MEM_BOUNDS_CHECK_EN.
// Latency: read data 1 cycle after acceptance. Backpressure: ready=0 only while clearing.
module data_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int BW    = DATA_W / 8;
    localparam int OFF_W = $clog2(BW);
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [AW-1:0]       widx;
    logic                acc;
    logic                rd_acc;
    logic                wr_acc;
    logic                oor;
    logic [DATA_W-1:0]   wmerge;

    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Upper address bits only matter for the range check; keep lint quiet otherwise.
    logic                unused_addr;
    assign unused_addr = ^addr;

    assign widx   = addr[OFF_W +: AW];
    assign acc    = req & ready;
    assign rd_acc = acc & ~we;
    assign wr_acc = acc & we;

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    assign oor = (addr >= 32'(DEPTH * BW));
`else
    assign oor = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Merge enabled byte lanes into the current word so the array sees whole-word writes.
    always_comb begin
        wmerge = mem_q[widx];
        for (int i = 0; i < BW; i++) begin
            if (be[i]) begin
                wmerge[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc && !oor) begin
            mem_q[widx] <= wmerge;
        end
    end

    always_comb begin
        rvalid_d = rd_acc;
        rdata_d  = rdata_q;
        if (rd_acc) begin
            rdata_d = oor ? '0 : mem_q[widx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    logic err_q, err_d;

    assign err_d = acc & oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DATA_W=32, DEPTH=16) with a behavioural reference model
// compared against the DUT after every rising edge, plus literal expectations per scenario.
module tb_data_mem_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DATA_W(DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .ready (ready),
        .rvalid(rvalid),
        .rdata (rdata),
        .err   (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image, remaining clear cycles and expected registered outputs.
    logic [31:0] mem_m [DEPTH];
    int          clr_left;
    logic        e_rvalid;
    logic        e_err;
    logic [31:0] e_rdata;

    initial begin
        int idx;
        bit oor;
        bit acc;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                clr_left = DEPTH;
                e_rvalid = 1'b0;
                e_err    = 1'b0;
                e_rdata  = '0;
                for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
            end else begin
                acc = (clr_left == 0) && (req === 1'b1);
                if (clr_left > 0) clr_left--;
                idx = int'(addr >> 2) % DEPTH;
                oor = 1'b0;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
                oor = (addr >= 32'(DEPTH * 4));
`endif
                e_rvalid = acc && !we;
                e_err    = acc && oor;
                if (acc && !we) e_rdata = oor ? 32'h0 : mem_m[idx];
                if (acc && we && !oor) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
            #1;
            chk("model_ready",  32'(ready),  32'(clr_left == 0));
            chk("model_rvalid", 32'(rvalid), 32'(e_rvalid));
            chk("model_rdata",  rdata,       e_rdata);
            chk("model_err",    32'(err),    32'(e_err));
        end
    end

    task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
        be  = '0;
    endtask

    // Releases reset at a falling edge and counts falling-edge samples with ready low.
    task automatic release_and_count(input string name);
        int n;
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'd16);
    endtask

    task automatic pulse_reset(input string name);
        rst_n = 1'b0;
        @(negedge clk);
        release_and_count(name);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(ready),  32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata",  rdata,       32'd0);
        chk("rst_err",    32'(err),    32'd0);

        release_and_count("clear_len_first");
        op(1'b0, 32'h3C, 32'h0, 4'h0);
        chk("rd3c_rvalid", 32'(rvalid), 32'd1);
        chk("rd3c_rdata",  rdata,       32'h0);

        op(1'b1, 32'h10, 32'h27, 4'hF);
        chk("wr_no_rvalid", 32'(rvalid), 32'd0);
        op(1'b0, 32'h10, 32'h0, 4'h0);
        chk("rd10_rdata", rdata, 32'h27);

        op(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0);
        op(1'b0, 32'h10, 32'h0, 4'h0);
        chk("be0_rdata", rdata, 32'h27);

        op(1'b1, 32'h04, 32'hAABBCCDD, 4'hF);
        op(1'b1, 32'h04, 32'h11223344, 4'h5);
        op(1'b0, 32'h04, 32'h0, 4'h0);
        chk("bytelane_rdata", rdata, 32'hAA22CC44);

        op(1'b1, 32'h00, 32'd1, 4'hF);
        op(1'b1, 32'h04, 32'd2, 4'hF);
        op(1'b1, 32'h08, 32'd3, 4'hF);
        op(1'b0, 32'h00, 32'h0, 4'h0);
        chk("b2b_rvalid0", 32'(rvalid), 32'd1);
        chk("b2b_rdata0",  rdata,       32'd1);
        op(1'b0, 32'h04, 32'h0, 4'h0);
        chk("b2b_rvalid1", 32'(rvalid), 32'd1);
        chk("b2b_rdata1",  rdata,       32'd2);
        op(1'b0, 32'h08, 32'h0, 4'h0);
        chk("b2b_rvalid2", 32'(rvalid), 32'd1);
        chk("b2b_rdata2",  rdata,       32'd3);
        @(negedge clk);
        chk("hold_rvalid", 32'(rvalid), 32'd0);
        chk("hold_rdata",  rdata,       32'd3);

        op(1'b1, 32'h00, 32'h5A, 4'hF);
        op(1'b0, 32'h40, 32'h0, 4'h0);
        chk("oor_rd_rvalid", 32'(rvalid), 32'd1);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
        chk("oor_rd_rdata", rdata,     32'h0);
        chk("oor_rd_err",   32'(err),  32'd1);
`else
        chk("wrap_rd_rdata", rdata,    32'h5A);
        chk("wrap_rd_err",   32'(err), 32'd0);
`endif
        op(1'b1, 32'h44, 32'hDEAD_BEEF, 4'hF);
        chk("oor_wr_rvalid", 32'(rvalid), 32'd0);
        op(1'b0, 32'h04, 32'h0, 4'h0);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
        chk("oor_wr_dropped", rdata, 32'd2);
`else
        chk("wrap_wr_lands", rdata, 32'hDEAD_BEEF);
`endif

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h08;
        wdata = 32'hFF;
        be    = 4'hF;
        repeat (7) @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
        be  = '0;
        chk("midclear_ready", 32'(ready), 32'd0);
        pulse_reset("clear_len_midclear");
        op(1'b0, 32'h08, 32'h0, 4'h0);
        chk("ignored_req_rdata", rdata, 32'h0);

        op(1'b1, 32'h08, 32'hFF, 4'hF);
        op(1'b0, 32'h08, 32'h0, 4'h0);
        chk("wr08_rdata", rdata, 32'hFF);
        pulse_reset("clear_len_idle");
        op(1'b0, 32'h08, 32'h0, 4'h0);
        chk("post_rst_rd08", rdata, 32'h0);
        op(1'b0, 32'h10, 32'h0, 4'h0);
        chk("post_rst_rd10", rdata, 32'h0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

endmodule
